// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - four-state bus sequencer moving 16-bit words between a register file, the shared bus and an external port
module bus_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] ext_data_in,
  input  logic [15:0] bus_in,
  output logic        bus_drive_en,
  output logic [15:0] bus_drive_data,
  output logic [5:0]  register_addr,
  output logic        bus_register_input_en,
  output logic        bus_register_output_en,
  output logic [15:0] ext_data_out,
  output logic        ext_data_valid,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, RD_SRC, WR_DST, FINISH} state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_CLR   = 4'd4;

  state_t      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [5:0]  a_q, a_d;
  logic [5:0]  b_q, b_d;
  logic [15:0] ext_in_q, ext_in_d;
  logic [15:0] temp_q, temp_d;
  logic [15:0] ext_out_q, ext_out_d;

  logic        ready_q, ready_d;
  logic        drive_en_q, drive_en_d;
  logic [15:0] drive_data_q, drive_data_d;
  logic [5:0]  addr_q, addr_d;
  logic        in_en_q, in_en_d;
  logic        out_en_q, out_en_d;
  logic        ext_valid_q, ext_valid_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;

  logic        accept;

  assign accept = instr_valid & ready_q;

  // Next-state and datapath latches
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    a_d       = a_q;
    b_d       = b_q;
    ext_in_d  = ext_in_q;
    temp_d    = temp_q;
    ext_out_d = ext_out_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          opcode_d = instruction[15:12];
          a_d      = instruction[11:6];
          b_d      = instruction[5:0];
          ext_in_d = ext_data_in;
          case (instruction[15:12])
            OP_MOV, OP_STORE: state_d = RD_SRC;
            OP_LOAD, OP_CLR:  state_d = WR_DST;
            default:          state_d = FINISH;
          endcase
        end
      end
      RD_SRC: begin
        temp_d = bus_in;
        if (opcode_q == OP_STORE) begin
          ext_out_d = bus_in;
          state_d   = FINISH;
        end else begin
          state_d = WR_DST;
        end
      end
      WR_DST:  state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output leaves a flop
  always_comb begin
    ready_d      = 1'b0;
    drive_en_d   = 1'b0;
    drive_data_d = 16'h0000;
    addr_d       = 6'd0;
    in_en_d      = 1'b0;
    out_en_d     = 1'b0;
    ext_valid_d  = 1'b0;
    done_d       = 1'b0;
    illegal_d    = 1'b0;

    case (state_d)
      IDLE: ready_d = 1'b1;
      RD_SRC: begin
        addr_d   = b_d;
        out_en_d = 1'b1;
      end
      WR_DST: begin
        addr_d     = a_d;
        drive_en_d = 1'b1;
        in_en_d    = 1'b1;
        case (opcode_d)
          OP_MOV:  drive_data_d = temp_d;
          OP_LOAD: drive_data_d = ext_in_d;
          default: drive_data_d = 16'h0000;
        endcase
      end
      FINISH: begin
        done_d      = 1'b1;
        illegal_d   = (opcode_d > OP_CLR);
        ext_valid_d = (opcode_d == OP_STORE);
      end
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      opcode_q     <= OP_NOP;
      a_q          <= 6'd0;
      b_q          <= 6'd0;
      ext_in_q     <= 16'h0000;
      temp_q       <= 16'h0000;
      ext_out_q    <= 16'h0000;
      ready_q      <= 1'b1;
      drive_en_q   <= 1'b0;
      drive_data_q <= 16'h0000;
      addr_q       <= 6'd0;
      in_en_q      <= 1'b0;
      out_en_q     <= 1'b0;
      ext_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ext_in_q     <= ext_in_d;
      temp_q       <= temp_d;
      ext_out_q    <= ext_out_d;
      ready_q      <= ready_d;
      drive_en_q   <= drive_en_d;
      drive_data_q <= drive_data_d;
      addr_q       <= addr_d;
      in_en_q      <= in_en_d;
      out_en_q     <= out_en_d;
      ext_valid_q  <= ext_valid_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
    end
  end

  assign instr_ready            = ready_q;
  assign bus_drive_en           = drive_en_q;
  assign bus_drive_data         = drive_data_q;
  assign register_addr          = addr_q;
  assign bus_register_input_en  = in_en_q;
  assign bus_register_output_en = out_en_q;
  assign ext_data_out           = ext_out_q;
  assign ext_data_valid         = ext_valid_q;
  assign done                   = done_q;
  assign illegal                = illegal_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed bench for bus_sequencer with a behavioural register file on the bus
module tb_bus_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] ext_data_in;
  logic [15:0] bus_in;
  logic        bus_drive_en;
  logic [15:0] bus_drive_data;
  logic [5:0]  register_addr;
  logic        bus_register_input_en;
  logic        bus_register_output_en;
  logic [15:0] ext_data_out;
  logic        ext_data_valid;
  logic        done;
  logic        illegal;

  int vectors = 0;
  int fails   = 0;
  logic monitor_on = 1'b0;

  logic [15:0] regs [64];

  always #5 clock = ~clock;

  bus_sequencer dut (
    .clock                  (clock),
    .reset                  (reset),
    .instruction            (instruction),
    .instr_valid            (instr_valid),
    .instr_ready            (instr_ready),
    .ext_data_in            (ext_data_in),
    .bus_in                 (bus_in),
    .bus_drive_en           (bus_drive_en),
    .bus_drive_data         (bus_drive_data),
    .register_addr          (register_addr),
    .bus_register_input_en  (bus_register_input_en),
    .bus_register_output_en (bus_register_output_en),
    .ext_data_out           (ext_data_out),
    .ext_data_valid         (ext_data_valid),
    .done                   (done),
    .illegal                (illegal)
  );

  // Register file and bus environment
  always_comb begin
    if (bus_drive_en)                bus_in = bus_drive_data;
    else if (bus_register_output_en) bus_in = regs[register_addr];
    else                             bus_in = 16'h0000;
  end

  always @(posedge clock) begin
    if (bus_register_input_en) regs[register_addr] <= bus_in;
  end

  always @(negedge clock) begin
    if (monitor_on) begin
      vectors++;
      assert (!((bus_drive_en && bus_register_output_en) ||
                (bus_register_input_en && bus_register_output_en)))
      else begin
        fails++;
        $error("FAIL mutex drive_en=%b out_en=%b in_en=%b required no overlap",
               bus_drive_en, bus_register_output_en, bus_register_input_en);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic rdy, input logic [5:0] addr,
                             input logic oe, input logic de, input logic ie,
                             input logic [15:0] dd, input logic dn, input logic il,
                             input logic ev);
    chk({tag, ".ready"},   {15'd0, instr_ready},            {15'd0, rdy});
    chk({tag, ".addr"},    {10'd0, register_addr},          {10'd0, addr});
    chk({tag, ".out_en"},  {15'd0, bus_register_output_en}, {15'd0, oe});
    chk({tag, ".drv_en"},  {15'd0, bus_drive_en},           {15'd0, de});
    chk({tag, ".in_en"},   {15'd0, bus_register_input_en},  {15'd0, ie});
    chk({tag, ".drv_dat"}, bus_drive_data,                  dd);
    chk({tag, ".done"},    {15'd0, done},                   {15'd0, dn});
    chk({tag, ".illegal"}, {15'd0, illegal},                {15'd0, il});
    chk({tag, ".ext_vld"}, {15'd0, ext_data_valid},         {15'd0, ev});
  endtask

  task automatic offer(input logic [15:0] ins, input logic [15:0] ext);
    instruction = ins;
    ext_data_in = ext;
    instr_valid = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 16'h0000;
    reset       = 1'b1;
    instruction = 16'h0000;
    instr_valid = 1'b0;
    ext_data_in = 16'h0000;

    tick();
    tick();
    monitor_on = 1'b1;
    expect_outs("rst", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);
    chk("rst.ext_out", ext_data_out, 16'h0000);
    reset = 1'b0;
    tick();
    expect_outs("post_rst", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);

    // MOV R9 <- R5 with instr_valid held high across two instructions
    regs[5] = 16'hBEEF;
    offer(16'h1245, 16'h0000);
    tick();
    expect_outs("mov1.rd", 0, 6'd5, 1, 0, 0, 16'h0000, 0, 0, 0);
    tick();
    expect_outs("mov1.wr", 0, 6'd9, 0, 1, 1, 16'hBEEF, 0, 0, 0);
    tick();
    expect_outs("mov1.fin", 0, 6'd0, 0, 0, 0, 16'h0000, 1, 0, 0);
    tick();
    expect_outs("mov1.idle", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);
    chk("mov1.r9", regs[9], 16'hBEEF);
    tick();
    expect_outs("mov2.rd", 0, 6'd5, 1, 0, 0, 16'h0000, 0, 0, 0);
    instr_valid = 1'b0;
    tick();
    expect_outs("mov2.wr", 0, 6'd9, 0, 1, 1, 16'hBEEF, 0, 0, 0);
    tick();
    expect_outs("mov2.fin", 0, 6'd0, 0, 0, 0, 16'h0000, 1, 0, 0);
    tick();
    expect_outs("mov2.idle", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);
    tick();
    expect_outs("mov2.quiet", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);

    // LOAD R3 <- 0x1234; ext_data_in changes after accept and must be ignored
    offer(16'h20C0, 16'h1234);
    tick();
    instr_valid = 1'b0;
    ext_data_in = 16'hFFFF;
    expect_outs("load.wr", 0, 6'd3, 0, 1, 1, 16'h1234, 0, 0, 0);
    tick();
    expect_outs("load.fin", 0, 6'd0, 0, 0, 0, 16'h0000, 1, 0, 0);
    tick();
    chk("load.r3", regs[3], 16'h1234);

    // STORE R3 -> ext_data_out
    offer(16'h3003, 16'h0000);
    tick();
    instr_valid = 1'b0;
    expect_outs("store.rd", 0, 6'd3, 1, 0, 0, 16'h0000, 0, 0, 0);
    tick();
    expect_outs("store.fin", 0, 6'd0, 0, 0, 0, 16'h0000, 1, 0, 1);
    chk("store.ext_out", ext_data_out, 16'h1234);
    tick();
    expect_outs("store.idle", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);
    chk("store.hold", ext_data_out, 16'h1234);

    // CLR R63
    regs[63] = 16'hAAAA;
    offer(16'h4FC0, 16'h5555);
    tick();
    instr_valid = 1'b0;
    expect_outs("clr.wr", 0, 6'd63, 0, 1, 1, 16'h0000, 0, 0, 0);
    tick();
    expect_outs("clr.fin", 0, 6'd0, 0, 0, 0, 16'h0000, 1, 0, 0);
    tick();
    chk("clr.r63", regs[63], 16'h0000);

    // Illegal opcodes 15 and 5, then NOP
    offer(16'hF000, 16'h0000);
    tick();
    instr_valid = 1'b0;
    expect_outs("ill15.fin", 0, 6'd0, 0, 0, 0, 16'h0000, 1, 1, 0);
    tick();
    expect_outs("ill15.idle", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);
    offer(16'h5FFF, 16'h0000);
    tick();
    instr_valid = 1'b0;
    expect_outs("ill5.fin", 0, 6'd0, 0, 0, 0, 16'h0000, 1, 1, 0);
    tick();
    offer(16'h0000, 16'h0000);
    tick();
    instr_valid = 1'b0;
    expect_outs("nop.fin", 0, 6'd0, 0, 0, 0, 16'h0000, 1, 0, 0);
    tick();
    chk("nop.ext_out", ext_data_out, 16'h1234);

    // Reset asserted during WR_DST of a MOV aborts it
    regs[5] = 16'hCAFE;
    offer(16'h1245, 16'h0000);
    tick();
    instr_valid = 1'b0;
    expect_outs("abort.rd", 0, 6'd5, 1, 0, 0, 16'h0000, 0, 0, 0);
    tick();
    expect_outs("abort.wr", 0, 6'd9, 0, 1, 1, 16'hCAFE, 0, 0, 0);
    reset = 1'b1;
    tick();
    expect_outs("abort.rst", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);
    chk("abort.ext_out", ext_data_out, 16'h0000);
    reset = 1'b0;
    tick();
    expect_outs("abort.after", 1, 6'd0, 0, 0, 0, 16'h0000, 0, 0, 0);

    monitor_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
